// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a one-entry skid for overflow.
// Latency 1 cycle; in_ready drops when the skid is full or hazard is raised, and never looks at out_ready.
module ex_mem_stage_reg #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_r0,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_reg,
    output logic [DATA_W-1:0] out_r0,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int ENT_W = RD_W + 3 * DATA_W + CTRL_W;

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [ENT_W-1:0] main_dat_q, main_dat_d;
    logic [ENT_W-1:0] skid_dat_q, skid_dat_d;
    logic [1:0]       occ_q, occ_d;
    logic [ENT_W-1:0] in_dat;
    logic             in_fire;
    logic             out_fire;

    assign in_dat    = {in_rd, in_alu, in_reg, in_r0, in_ctrl};
    assign in_ready  = !skid_vld_q && !hazard;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_vld_q;
    assign out_fire  = main_vld_q && out_ready;
    assign occupancy = occ_q;
    assign {out_rd, out_alu, out_reg, out_r0, out_ctrl} = main_dat_q;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_vld_d = 1'b0;
            main_dat_d = '0;
            skid_vld_d = 1'b0;
            skid_dat_d = '0;
        end else if (!main_vld_q || out_fire) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = in_fire;
                if (in_fire) begin
                    skid_dat_d = in_dat;
                end
            end else if (in_fire) begin
                main_vld_d = 1'b1;
                main_dat_d = in_dat;
            end else begin
                // Bubble: drop valid but keep the fields so out_* stays quiet.
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
        occ_d = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            occ_q      <= 2'd0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: queue-based reference model checked every cycle plus directed literal checks.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hazard = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rd = '0;
    logic [15:0] in_alu = '0;
    logic [15:0] in_reg = '0;
    logic [15:0] in_r0 = '0;
    logic [3:0]  in_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_rd;
    logic [15:0] out_alu;
    logic [15:0] out_reg;
    logic [15:0] out_r0;
    logic [3:0]  out_ctrl;
    logic [1:0]  occupancy;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [4:0]  w_out_rd;
    logic [31:0] w_out_alu;
    logic [31:0] w_out_reg;
    logic [31:0] w_out_r0;
    logic [3:0]  w_out_ctrl;
    logic [1:0]  w_occupancy;
    logic        w_hazard = 1'b0;
    logic        w_flush = 1'b0;
    logic        w_in_valid = 1'b1;
    logic [4:0]  w_in_rd = 5'h1F;
    logic [31:0] w_in_alu = 32'h1234_5678;
    logic [31:0] w_in_reg = 32'h0BAD_F00D;
    logic [31:0] w_in_r0 = 32'hDEAD_BEEF;
    logic [3:0]  w_in_ctrl = 4'hA;
    logic        w_out_ready = 1'b1;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk(clk), .reset(reset), .hazard(hazard), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_alu(in_alu), .in_reg(in_reg), .in_r0(in_r0), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_alu(out_alu), .out_reg(out_reg), .out_r0(out_r0), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    ex_mem_stage_reg #(.DATA_W(32), .RD_W(5), .CTRL_W(4)) dut_w (
        .clk(clk), .reset(reset), .hazard(w_hazard), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_rd(w_in_rd), .in_alu(w_in_alu), .in_reg(w_in_reg), .in_r0(w_in_r0), .in_ctrl(w_in_ctrl),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_rd(w_out_rd), .out_alu(w_out_alu), .out_reg(w_out_reg), .out_r0(w_out_r0), .out_ctrl(w_out_ctrl),
        .occupancy(w_occupancy)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] alu;
        logic [15:0] opnd;
        logic [15:0] r0;
        logic [3:0]  ctrl;
    } ent_t;

    ent_t q[$];
    ent_t held;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: the stage is a FIFO of depth 2; out_* shows the head, or the last head when empty.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            held = '0;
        end else begin
            bit   inf;
            bit   outf;
            ent_t e;
            inf  = in_valid && (q.size() < 2) && !hazard;
            outf = (q.size() > 0) && out_ready;
            e    = '{rd: in_rd, alu: in_alu, opnd: in_reg, r0: in_r0, ctrl: in_ctrl};
            if (flush) begin
                q.delete();
                held = '0;
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(e);
                if (q.size() > 0) held = q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) && !hazard));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("out_rd", 32'(out_rd), 32'(held.rd));
            chk("out_alu", 32'(out_alu), 32'(held.alu));
            chk("out_reg", 32'(out_reg), 32'(held.opnd));
            chk("out_r0", 32'(out_r0), 32'(held.r0));
            chk("out_ctrl", 32'(out_ctrl), 32'(held.ctrl));
        end
    end

    task automatic set(input logic v, input logic [15:0] alu, input logic ordy,
                       input logic hz, input logic fl);
        in_valid  = v;
        in_alu    = alu;
        out_ready = ordy;
        hazard    = hz;
        flush     = fl;
        in_rd     = 4'($urandom);
        in_reg    = 16'($urandom);
        in_r0     = 16'($urandom);
        in_ctrl   = 4'($urandom);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_alu", 32'(out_alu), 32'd0);
        cyc();
        reset = 1'b1;
        chk_en = 1'b1;

        // Stream three entries with no backpressure
        set(1, 16'h0011, 1, 0, 0);
        cyc();
        chk("s1_alu", 32'(out_alu), 32'h0011);
        chk("s1_occ", 32'(occupancy), 32'd1);
        chk("wide_r0", w_out_r0, 32'hDEAD_BEEF);
        chk("wide_rd", 32'(w_out_rd), 32'h1F);
        chk("wide_valid", 32'(w_out_valid), 32'd1);
        set(1, 16'h0022, 1, 0, 0);
        cyc();
        chk("s2_alu", 32'(out_alu), 32'h0022);
        set(1, 16'h0033, 1, 0, 0);
        cyc();
        chk("s3_alu", 32'(out_alu), 32'h0033);
        chk("s3_occ", 32'(occupancy), 32'd1);
        set(0, 16'h0000, 1, 0, 0);
        cyc();
        chk("s_empty_valid", 32'(out_valid), 32'd0);
        chk("s_hold_alu", 32'(out_alu), 32'h0033);

        // Fill under backpressure
        set(1, 16'h00A1, 0, 0, 0);
        cyc();
        set(1, 16'h00A2, 0, 0, 0);
        cyc();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        set(1, 16'h00A3, 0, 0, 0);
        cyc();
        chk("bp_hold_alu", 32'(out_alu), 32'h00A1);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        set(1, 16'h00A3, 1, 0, 0);
        cyc();
        chk("bp_drain_a2", 32'(out_alu), 32'h00A2);
        cyc();
        chk("bp_drain_a3", 32'(out_alu), 32'h00A3);
        set(0, 16'h0000, 1, 0, 0);
        cyc();
        chk("bp_empty_occ", 32'(occupancy), 32'd0);

        // Hazard blocks capture but the held entry still drains
        set(1, 16'h0C01, 0, 0, 0);
        cyc();
        set(1, 16'h0BEE, 1, 1, 0);
        #1;
        chk("hz_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("hz_drained_valid", 32'(out_valid), 32'd0);
        chk("hz_no_capture_occ", 32'(occupancy), 32'd0);
        set(1, 16'h0BEE, 1, 0, 0);
        cyc();
        chk("hz_capture_alu", 32'(out_alu), 32'h0BEE);
        chk("hz_capture_valid", 32'(out_valid), 32'd1);

        // Flush with both entries held and an offered input
        set(1, 16'h00D1, 0, 0, 0);
        cyc();
        set(1, 16'h00D2, 0, 0, 0);
        cyc();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        set(1, 16'h00D3, 0, 0, 1);
        cyc();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_alu", 32'(out_alu), 32'd0);
        chk("fl_rd", 32'(out_rd), 32'd0);
        chk("fl_r0", 32'(out_r0), 32'd0);
        set(0, 16'h0000, 0, 0, 0);
        cyc();
        chk("fl_dropped_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset pulse mid-cycle
        set(1, 16'h00E1, 0, 0, 0);
        cyc();
        chk("ar_pre_occ", 32'(occupancy), 32'd1);
        set(0, 16'h0000, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_alu", 32'(out_alu), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        cyc();
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 39) == 0));
            cyc();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
